// File: rtl/sample_serializer.sv
// Byte-wide serializer: pops samples from a show-ahead FIFO and hands them to
// the FX2 side LSB first over a ready/ack handshake, with byte/sample counters.
module sample_serializer #(
  parameter  int SAMPLE_WIDTH = 48,
  localparam int NBYTES       = SAMPLE_WIDTH / 8,
  localparam int IDX_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                    fx2_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sample_rdy,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_ack,
  output logic                    data_rdy,
  output logic [7:0]              data,
  input  logic                    data_ack,
  output logic [15:0]             byte_count,
  output logic [15:0]             sample_count,
  output logic                    busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t                  state, next_state;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]        idx;
  logic                    take, last_take, load;

  assign data_rdy   = (state == SEND);
  assign busy       = data_rdy;
  assign data       = shreg[7:0];
  assign take       = data_rdy & data_ack;
  assign last_take  = take & (idx == LAST_IDX);
  // Reloading on the last byte keeps back-to-back samples free of bubbles.
  assign load       = reset_n & enable & sample_rdy & ((state == IDLE) | last_take);
  assign sample_ack = load;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (load) next_state = SEND;
      SEND:    if (last_take && !load) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg        <= '0;
      idx          <= '0;
      byte_count   <= '0;
      sample_count <= '0;
    end else begin
      if (load) begin
        shreg <= sample;
        idx   <= '0;
      end else if (take && !last_take) begin
        shreg <= shreg >> 8;
        idx   <= idx + IDX_W'(1);
      end
      if (take)      byte_count   <= byte_count + 16'd1;
      if (last_take) sample_count <= sample_count + 16'd1;
    end
  end

endmodule
